// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard logic: MIPS opcodes and the
// scoreboard entry layout.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int REG_W   = 5;
    localparam int LCNT_W  = 3;

    // One in-flight load: destination register and remaining bubble count.
    // The entry is live while cnt is nonzero.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [LCNT_W-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/src_decode.sv
// Decodes which register fields of an instruction are read as sources,
// and whether it is a load. Purely combinational.
module src_decode
    import hazard_pkg::*;
#(
    parameter int STORE_RT_FWD = 1
) (
    input  logic [31:0]      instr_i,
    output logic             rs_use_o,
    output logic             rt_use_o,
    output logic [REG_W-1:0] rs_o,
    output logic [REG_W-1:0] rt_o,
    output logic             is_load_o
);

    logic [5:0] opcode;
    logic       unused_low_bits;

    assign opcode          = instr_i[31:26];
    assign rs_o            = instr_i[25:21];
    assign rt_o            = instr_i[20:16];
    assign is_load_o       = (opcode == OP_LW);
    assign unused_low_bits = ^instr_i[15:0];

    // Source usage per opcode; unknown opcodes conservatively read both.
    always_comb begin
        rs_use_o = 1'b1;
        rt_use_o = 1'b1;
        case (opcode)
            OP_RTYPE, OP_BEQ, OP_BNE: begin
                rs_use_o = 1'b1;
                rt_use_o = 1'b1;
            end
            OP_LW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                rs_use_o = 1'b1;
                rt_use_o = 1'b0;
            end
            OP_SW: begin
                rs_use_o = 1'b1;
                rt_use_o = (STORE_RT_FWD == 0);
            end
            OP_J, OP_LUI: begin
                rs_use_o = 1'b0;
                rt_use_o = 1'b0;
            end
            default: begin
                rs_use_o = 1'b1;
                rt_use_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_use_scoreboard.sv
// Multi-cycle load-use hazard detector: tracks in-flight loads with
// per-entry bubble countdowns and stalls dependents in ID accordingly.
module load_use_scoreboard
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int NUM_PENDING  = 2,
    parameter int STORE_RT_FWD = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      id_instr_i,
    input  logic             id_valid_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    sb_entry_t              sb_q [NUM_PENDING];
    sb_entry_t              sb_d [NUM_PENDING];
    logic [CNT_W-1:0]       stall_cnt_q;
    logic [CNT_W-1:0]       stall_cnt_d;

    logic                   rs_use;
    logic                   rt_use;
    logic [REG_W-1:0]       rs;
    logic [REG_W-1:0]       rt;
    logic                   is_load;

    logic [NUM_PENDING-1:0] live_vec;
    logic [NUM_PENDING-1:0] src_hit_vec;
    logic [NUM_PENDING-1:0] rt_match_vec;
    logic [NUM_PENDING-1:0] free_vec;
    logic [NUM_PENDING-1:0] alloc_vec;

    logic                   active;
    logic                   hazard;
    logic                   full_stall;
    logic                   stall;
    logic                   issue_load;

    src_decode #(
        .STORE_RT_FWD (STORE_RT_FWD)
    ) u_src_decode (
        .instr_i   (id_instr_i),
        .rs_use_o  (rs_use),
        .rt_use_o  (rt_use),
        .rs_o      (rs),
        .rt_o      (rt),
        .is_load_o (is_load)
    );

    // Per-entry comparisons; register 0 never matches anything.
    for (genvar gi = 0; gi < NUM_PENDING; gi++) begin : g_entry
        assign live_vec[gi]     = (sb_q[gi].cnt != '0);
        assign src_hit_vec[gi]  = live_vec[gi] &
                                  ((rs_use && rs != '0 && sb_q[gi].rd == rs) ||
                                   (rt_use && rt != '0 && sb_q[gi].rd == rt));
        assign rt_match_vec[gi] = live_vec[gi] && (sb_q[gi].rd == rt);
    end

    assign free_vec  = ~live_vec;
    // Lowest set bit of free_vec selects the entry to allocate.
    assign alloc_vec = free_vec & (~free_vec + 1'b1);

    assign active     = id_valid_i && !flush_i;
    assign hazard     = active && (|src_hit_vec);
    assign full_stall = active && is_load && (rt != '0) &&
                        !(|rt_match_vec) && !(|free_vec);
    assign stall      = !rst_i && (hazard || full_stall);
    assign issue_load = active && !stall && is_load && (rt != '0);

    assign stall_o     = stall;
    assign bubble_o    = stall;
    assign stall_cnt_o = stall_cnt_q;

    // Next scoreboard state: live entries count down; an issuing load either
    // refreshes the entry already tracking its rt or takes the lowest free one.
    always_comb begin
        for (int i = 0; i < NUM_PENDING; i++) begin
            sb_d[i] = sb_q[i];
            if (live_vec[i]) begin
                sb_d[i].cnt = sb_q[i].cnt - 1'b1;
            end
            if (issue_load && ((|rt_match_vec) ? rt_match_vec[i] : alloc_vec[i])) begin
                sb_d[i].rd  = rt;
                sb_d[i].cnt = LCNT_W'(LOAD_LAT);
            end
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset that discards pending loads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PENDING; i++) begin
                sb_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PENDING; i++) begin
                sb_q[i] <= sb_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench: two scoreboard configurations, expected stall/bubble/count
// values queued by the driver and checked by an independent monitor.
module tb_load_use_scoreboard;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: LOAD_LAT=3, NUM_PENDING=2, STORE_RT_FWD=1, CNT_W=16
    logic [31:0] instr_a = '0;
    logic        valid_a = 1'b0, flush_a = 1'b0, rst_a = 1'b1;
    logic        stall_a, bubble_a;
    logic [15:0] cnt_a;
    // DUT B: LOAD_LAT=1, NUM_PENDING=2, STORE_RT_FWD=0, CNT_W=4
    logic [31:0] instr_b = '0;
    logic        valid_b = 1'b0, flush_b = 1'b0, rst_b = 1'b1;
    logic        stall_b, bubble_b;
    logic [3:0]  cnt_b;

    load_use_scoreboard #(.LOAD_LAT(3), .NUM_PENDING(2), .STORE_RT_FWD(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .id_instr_i(instr_a), .id_valid_i(valid_a),
        .flush_i(flush_a), .stall_o(stall_a), .bubble_o(bubble_a), .stall_cnt_o(cnt_a));

    load_use_scoreboard #(.LOAD_LAT(1), .NUM_PENDING(2), .STORE_RT_FWD(0), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .id_instr_i(instr_b), .id_valid_i(valid_b),
        .flush_i(flush_b), .stall_o(stall_b), .bubble_o(bubble_b), .stall_cnt_o(cnt_b));

    typedef struct {
        int    sel;
        logic  exp_stall;
        logic  chk_cnt;
        int    exp_cnt;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, ADDI = 6'b001000;

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs_r, input int rt_r, input int imm);
        return {op, 5'(rs_r), 5'(rt_r), 16'(imm)};
    endfunction

    function automatic logic [31:0] add(input int rd_r, input int rs_r, input int rt_r);
        return {6'd0, 5'(rs_r), 5'(rt_r), 5'(rd_r), 5'd0, 6'h20};
    endfunction

    // Apply one cycle of stimulus to the selected DUT and queue its expectation.
    task automatic step(input int sel, input logic [31:0] ins, input logic v, input logic fl,
                        input logic rs, input logic es, input logic cc, input int ec,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        instr_a = ins; valid_a = 1'b0; flush_a = 1'b0; rst_a = 1'b0;
        instr_b = ins; valid_b = 1'b0; flush_b = 1'b0; rst_b = 1'b0;
        if (sel == 0) begin
            valid_a = v; flush_a = fl; rst_a = rs;
        end else begin
            valid_b = v; flush_b = fl; rst_b = rs;
        end
        e.sel = sel; e.exp_stall = es; e.chk_cnt = cc; e.exp_cnt = ec; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic st, bb;
            int   ct;
            e  = exp_q.pop_front();
            st = (e.sel == 0) ? stall_a : stall_b;
            bb = (e.sel == 0) ? bubble_a : bubble_b;
            ct = (e.sel == 0) ? int'(cnt_a) : int'(cnt_b);
            n_checks++;
            if (st !== e.exp_stall) begin
                n_errors++;
                $display("FAIL %s stall: got %0b want %0b", e.name, st, e.exp_stall);
            end
            n_checks++;
            if (bb !== e.exp_stall) begin
                n_errors++;
                $display("FAIL %s bubble: got %0b want %0b", e.name, bb, e.exp_stall);
            end
            if (e.chk_cnt) begin
                n_checks++;
                if (ct != e.exp_cnt) begin
                    n_errors++;
                    $display("FAIL %s count: got %0d want %0d", e.name, ct, e.exp_cnt);
                end
            end
            $display("txn dut=%0d %-14s stall=%0b bubble=%0b cnt=%0d", e.sel, e.name, st, bb, ct);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;

        // ---------------- DUT A (LOAD_LAT=3, FWD=1) ----------------
        step(0, 32'd0, 0, 0, 0, 0, 1, 0, "a_reset_state");
        step(0, itype(LW, 1, 5, 0),   1, 0, 0, 0, 0, 0, "a_lw5");
        step(0, itype(BEQ, 5, 0, 4),  1, 0, 0, 1, 0, 0, "a_beq_s1");
        step(0, itype(BEQ, 5, 0, 4),  1, 0, 0, 1, 0, 0, "a_beq_s2");
        step(0, itype(BEQ, 5, 0, 4),  1, 0, 0, 1, 0, 0, "a_beq_s3");
        step(0, itype(BEQ, 5, 0, 4),  1, 0, 0, 0, 1, 3, "a_beq_go");
        step(0, itype(LW, 1, 5, 0),   1, 0, 0, 0, 0, 0, "a_lw5_again");
        step(0, itype(ADDI, 7, 6, 1), 1, 0, 0, 0, 0, 0, "a_addi_indep");
        step(0, itype(LW, 1, 0, 0),   1, 0, 0, 0, 0, 0, "a_lw0");
        step(0, add(1, 0, 0),         1, 0, 0, 0, 0, 0, "a_add_r0");
        // Structural stall with two entries, then entry reuse
        step(0, itype(LW, 9, 1, 0),   1, 0, 0, 0, 0, 0, "a_lw1");
        step(0, itype(LW, 9, 2, 0),   1, 0, 0, 0, 0, 0, "a_lw2");
        step(0, itype(LW, 9, 3, 0),   1, 0, 0, 1, 0, 0, "a_lw3_full1");
        step(0, itype(LW, 9, 3, 0),   1, 0, 0, 1, 0, 0, "a_lw3_full2");
        step(0, itype(LW, 9, 3, 0),   1, 0, 0, 0, 0, 0, "a_lw3_issue");
        step(0, itype(LW, 9, 7, 0),   1, 0, 0, 0, 0, 0, "a_lw7");
        step(0, itype(LW, 9, 3, 0),   1, 0, 0, 0, 0, 0, "a_lw3_reuse");
        step(0, add(9, 3, 0),         1, 0, 0, 1, 0, 0, "a_dep3_s1");
        step(0, add(9, 3, 0),         1, 0, 0, 1, 0, 0, "a_dep3_s2");
        step(0, add(9, 3, 0),         1, 0, 0, 1, 0, 0, "a_dep3_s3");
        step(0, add(9, 3, 0),         1, 0, 0, 0, 1, 8, "a_dep3_go");
        // Store data forwarded: only base register is a source
        step(0, itype(LW, 9, 4, 0),   1, 0, 0, 0, 0, 0, "a_lw4");
        step(0, itype(SW, 8, 4, 0),   1, 0, 0, 0, 0, 0, "a_sw_rt4");
        step(0, itype(LW, 9, 8, 0),   1, 0, 0, 0, 0, 0, "a_lw8");
        step(0, itype(SW, 8, 4, 0),   1, 0, 0, 1, 0, 0, "a_sw_rs8_s1");
        step(0, itype(SW, 8, 4, 0),   1, 0, 0, 1, 0, 0, "a_sw_rs8_s2");
        step(0, itype(SW, 8, 4, 0),   1, 0, 0, 1, 0, 0, "a_sw_rs8_s3");
        step(0, itype(SW, 8, 4, 0),   1, 0, 0, 0, 1, 11, "a_sw_rs8_go");
        // Flush suppresses stall; entry keeps counting
        step(0, itype(LW, 1, 10, 0),  1, 0, 0, 0, 0, 0, "a_lw10");
        step(0, add(11, 10, 0),       1, 1, 0, 0, 0, 0, "a_dep_flushed");
        step(0, add(11, 10, 0),       1, 0, 0, 1, 0, 0, "a_dep_s1");
        step(0, add(11, 10, 0),       1, 0, 0, 1, 0, 0, "a_dep_s2");
        step(0, add(11, 10, 0),       1, 0, 0, 0, 0, 0, "a_dep_go");
        step(0, itype(LW, 1, 12, 0),  1, 1, 0, 0, 0, 0, "a_lw12_flushed");
        step(0, add(13, 12, 0),       1, 0, 0, 0, 0, 0, "a_no_entry12");
        // Reset with two live entries
        step(0, itype(LW, 1, 14, 0),  1, 0, 0, 0, 0, 0, "a_lw14");
        step(0, itype(LW, 1, 15, 0),  1, 0, 0, 0, 1, 13, "a_lw15");
        step(0, add(16, 14, 15),      1, 0, 1, 0, 0, 0, "a_in_reset");
        step(0, add(16, 14, 15),      1, 0, 0, 0, 1, 0, "a_after_reset");

        // ---------------- DUT B (LOAD_LAT=1, FWD=0, CNT_W=4) ----------------
        step(1, 32'd0, 0, 0, 0, 0, 1, 0, "b_reset_state");
        step(1, itype(LW, 1, 2, 0),   1, 0, 0, 0, 0, 0, "b_lw2");
        step(1, add(3, 2, 4),         1, 0, 0, 1, 0, 0, "b_add_s1");
        step(1, add(3, 2, 4),         1, 0, 0, 0, 1, 1, "b_add_go");
        step(1, itype(LW, 9, 4, 0),   1, 0, 0, 0, 0, 0, "b_lw4");
        step(1, itype(SW, 8, 4, 0),   1, 0, 0, 1, 0, 0, "b_sw_rt4_s1");
        step(1, itype(SW, 8, 4, 0),   1, 0, 0, 0, 1, 2, "b_sw_rt4_go");
        step(1, itype(LW, 9, 8, 0),   1, 0, 0, 0, 0, 0, "b_lw8");
        step(1, itype(SW, 8, 4, 0),   1, 0, 0, 1, 0, 0, "b_sw_rs8_s1");
        step(1, itype(SW, 8, 4, 0),   1, 0, 0, 0, 1, 3, "b_sw_rs8_go");
        for (int i = 0; i < 20; i++) begin
            step(1, itype(LW, 1, 2, 0), 1, 0, 0, 0, 0, 0, "b_sat_lw");
            step(1, add(3, 2, 4),       1, 0, 0, 1, 0, 0, "b_sat_dep");
        end
        step(1, 32'd0, 0, 0, 0, 0, 1, 15, "b_saturated");
        step(1, 32'd0, 0, 0, 0, 0, 1, 15, "b_sat_hold");
        step(1, itype(LW, 1, 2, 0),   1, 0, 1, 0, 0, 0, "b_in_reset");
        step(1, add(3, 2, 4),         1, 0, 0, 0, 1, 0, "b_after_reset");

        @(posedge clk);
        #1;
        valid_a = 1'b0; valid_b = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
